// File: rtl/usr_burst_shifter_pkg.sv
// Shared types for the burst shifter: op codes, FSM states and op-field width.
package usr_pkg;

   localparam int unsigned USR_OP_W = 3;

   typedef enum logic [USR_OP_W-1:0] {
      OP_HOLD = 3'd0,
      OP_LOAD = 3'd1,
      OP_SHL  = 3'd2,
      OP_SHR  = 3'd3,
      OP_ASR  = 3'd4,
      OP_ROL  = 3'd5,
      OP_ROR  = 3'd6,
      OP_CLR  = 3'd7
   } usr_op_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } usr_state_t;

endpackage

// File: rtl/usr_burst_shifter_step.sv
// Combinational single-bit shift/rotate step of width N.
// Rotates exist only when USR_ROTATE_EN is defined; otherwise ROL/ROR act as SHL/SHR.
module usr_step
   import usr_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic [USR_OP_W-1:0] i_op,
   input  logic                i_ser_in,
   input  logic [N-1:0]        i_cur,
   output logic [N-1:0]        o_nxt
);

   always_comb begin
      o_nxt = i_cur;
      case (usr_op_t'(i_op))
         OP_SHL:  o_nxt = {i_cur[N-2:0], i_ser_in};
         OP_SHR:  o_nxt = {i_ser_in, i_cur[N-1:1]};
         OP_ASR:  o_nxt = {i_cur[N-1], i_cur[N-1:1]};
`ifdef USR_ROTATE_EN
         OP_ROL:  o_nxt = {i_cur[N-2:0], i_cur[N-1]};
         OP_ROR:  o_nxt = {i_cur[0], i_cur[N-1:1]};
`else
         OP_ROL:  o_nxt = {i_cur[N-2:0], i_ser_in};
         OP_ROR:  o_nxt = {i_ser_in, i_cur[N-1:1]};
`endif
         default: o_nxt = i_cur;
      endcase
   end

endmodule

// File: rtl/usr_burst_shifter.sv
// Universal shift register with command handshake; multi-bit shifts run one bit per cycle.
// Optional rotate datapath enabled by defining USR_ROTATE_EN.
module usr_burst_shifter
   import usr_pkg::*;
#(
   parameter int unsigned N         = 8,
   parameter int unsigned MAX_SHIFT = N,
   parameter int unsigned AW        = $clog2(MAX_SHIFT + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N-1:0]        D_in,
   output logic [N-1:0]        D_out,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [USR_OP_W-1:0] cmd_op,
   input  logic [AW-1:0]       cmd_amt,
   input  logic                ser_in,
   input  logic                en,
   output logic                ser_out_msb,
   output logic                ser_out_lsb,
   output logic                busy,
   output logic                done
);

   localparam logic [AW-1:0] MAX_AMT = AW'(MAX_SHIFT);

   usr_state_t          r_state;
   usr_op_t             r_op;
   logic [AW-1:0]       r_cnt;
   logic [N-1:0]        r_dout;
   logic                r_done;

   usr_op_t             w_cmd_op;
   logic [AW-1:0]       w_amt;
   logic [USR_OP_W-1:0] w_step_op;
   logic [N-1:0]        w_step;

   assign w_cmd_op  = usr_op_t'(cmd_op);
   assign w_amt     = (cmd_amt > MAX_AMT) ? MAX_AMT : cmd_amt;
   // The step unit follows the latched op during a burst and the incoming op on accept.
   assign w_step_op = (r_state == ST_SHIFT) ? r_op : cmd_op;

   usr_step #(
      .N (N)
   ) u_step (
      .i_op     (w_step_op),
      .i_ser_in (ser_in),
      .i_cur    (r_dout),
      .o_nxt    (w_step)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_op    <= OP_HOLD;
         r_cnt   <= '0;
         r_dout  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  case (w_cmd_op)
                     OP_HOLD: r_done <= 1'b1;
                     OP_LOAD: begin
                        r_dout <= D_in;
                        r_done <= 1'b1;
                     end
                     OP_CLR: begin
                        r_dout <= '0;
                        r_done <= 1'b1;
                     end
                     default: begin
                        if (w_amt == '0) begin
                           r_done <= 1'b1;
                        end else begin
                           r_dout <= w_step;
                           if (w_amt == AW'(1)) begin
                              r_done <= 1'b1;
                           end else begin
                              r_cnt   <= w_amt - AW'(1);
                              r_op    <= w_cmd_op;
                              r_state <= ST_SHIFT;
                           end
                        end
                     end
                  endcase
               end
            end
            ST_SHIFT: begin
               if (en) begin
                  r_dout <= w_step;
                  r_cnt  <= r_cnt - AW'(1);
                  if (r_cnt == AW'(1)) begin
                     r_state <= ST_IDLE;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign D_out       = r_dout;
   assign ser_out_msb = r_dout[N-1];
   assign ser_out_lsb = r_dout[0];
   assign busy        = (r_state == ST_SHIFT);
   assign cmd_ready   = (r_state == ST_IDLE);
   assign done        = r_done;

endmodule

// File: tb/tb_usr_burst_shifter.sv
// Scoreboard bench for usr_burst_shifter (N=8): expected results queued at issue, checked on done.
module tb_usr_burst_shifter;
   import usr_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] D_in = '0;
   logic [7:0] D_out;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = '0;
   logic [3:0] cmd_amt = '0;
   logic       ser_in = 1'b0;
   logic       en = 1'b1;
   logic       ser_out_msb, ser_out_lsb, busy, done;

   typedef struct {
      string      nm;
      logic [7:0] v;
   } sb_e_t;

   sb_e_t sb[$];
   sb_e_t m_e;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned busy_cnt = 0;
   int unsigned done_cnt = 0;

   usr_burst_shifter #(
      .N (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .D_in        (D_in),
      .D_out       (D_out),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_amt     (cmd_amt),
      .ser_in      (ser_in),
      .en          (en),
      .ser_out_msb (ser_out_msb),
      .ser_out_lsb (ser_out_lsb),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (busy) busy_cnt++;
      if (done) begin
         done_cnt++;
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            m_e = sb.pop_front();
            chk(m_e.nm, {24'd0, D_out}, {24'd0, m_e.v});
            chk({m_e.nm, "_msb"}, {31'd0, ser_out_msb}, {31'd0, m_e.v[7]});
            chk({m_e.nm, "_lsb"}, {31'd0, ser_out_lsb}, {31'd0, m_e.v[0]});
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [3:0] amt, input logic [7:0] din,
                        input logic si, input bit push, input string nm, input logic [7:0] exp);
      int unsigned t = 0;
      sb_e_t e;
      @(negedge clk);
      while (!cmd_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!cmd_ready) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_amt   = amt;
      D_in      = din;
      ser_in    = si;
      busy_cnt  = 0;
      done_cnt  = 0;
      if (push) begin
         e.nm = nm;
         e.v  = exp;
         sb.push_back(e);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic finish_cmd(input string nm, input int unsigned exp_busy);
      int unsigned t = 0;
      while ((busy || sb.size() != 0) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk({nm, "_done_timeout"}, 32'd0, 32'd1);
      chk({nm, "_busy_cycles"}, busy_cnt, exp_busy);
      chk({nm, "_done_pulses"}, done_cnt, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_dout", {24'd0, D_out}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_ser_out", {30'd0, ser_out_msb, ser_out_lsb}, 32'd0);

      issue(OP_LOAD, 4'd0, 8'h0B, 1'b0, 1'b1, "load_0b", 8'h0B);
      finish_cmd("load_0b", 0);
      issue(OP_SHL, 4'd3, 8'h00, 1'b0, 1'b1, "shl3", 8'h58);
      finish_cmd("shl3", 2);

      issue(OP_LOAD, 4'd0, 8'h80, 1'b0, 1'b1, "load_80a", 8'h80);
      finish_cmd("load_80a", 0);
      issue(OP_ASR, 4'd2, 8'h00, 1'b0, 1'b1, "asr2", 8'hE0);
      finish_cmd("asr2", 1);
      issue(OP_LOAD, 4'd0, 8'h80, 1'b0, 1'b1, "load_80b", 8'h80);
      finish_cmd("load_80b", 0);
      issue(OP_SHR, 4'd2, 8'h00, 1'b1, 1'b1, "shr2_fill1", 8'hE0);
      finish_cmd("shr2_fill1", 1);
      issue(OP_LOAD, 4'd0, 8'h80, 1'b0, 1'b1, "load_80c", 8'h80);
      finish_cmd("load_80c", 0);
      issue(OP_SHR, 4'd2, 8'h00, 1'b0, 1'b1, "shr2_fill0", 8'h20);
      finish_cmd("shr2_fill0", 1);

      issue(OP_LOAD, 4'd0, 8'h0B, 1'b0, 1'b1, "load_0b_r", 8'h0B);
      finish_cmd("load_0b_r", 0);
`ifdef USR_ROTATE_EN
      issue(OP_ROR, 4'd1, 8'h00, 1'b0, 1'b1, "ror1", 8'h85);
`else
      issue(OP_ROR, 4'd1, 8'h00, 1'b0, 1'b1, "ror1", 8'h05);
`endif
      finish_cmd("ror1", 0);
      issue(OP_LOAD, 4'd0, 8'h81, 1'b0, 1'b1, "load_81", 8'h81);
      finish_cmd("load_81", 0);
`ifdef USR_ROTATE_EN
      issue(OP_ROL, 4'd2, 8'h00, 1'b1, 1'b1, "rol2", 8'h06);
`else
      issue(OP_ROL, 4'd2, 8'h00, 1'b1, 1'b1, "rol2", 8'h07);
`endif
      finish_cmd("rol2", 1);

      issue(OP_LOAD, 4'd0, 8'h5A, 1'b0, 1'b1, "load_5a", 8'h5A);
      finish_cmd("load_5a", 0);
      issue(OP_HOLD, 4'd3, 8'hFF, 1'b1, 1'b1, "hold", 8'h5A);
      finish_cmd("hold", 0);
      issue(OP_SHL, 4'd0, 8'hFF, 1'b1, 1'b1, "shl_amt0", 8'h5A);
      finish_cmd("shl_amt0", 0);
      issue(OP_CLR, 4'd0, 8'hFF, 1'b1, 1'b1, "clr", 8'h00);
      finish_cmd("clr", 0);

      // Stall two cycles mid-burst while a command is offered; it must be dropped.
      issue(OP_LOAD, 4'd0, 8'h01, 1'b0, 1'b1, "load_01", 8'h01);
      finish_cmd("load_01", 0);
      issue(OP_SHL, 4'd4, 8'h00, 1'b0, 1'b1, "shl4_stall", 8'h10);
      en        = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = OP_LOAD;
      D_in      = 8'hFF;
      @(negedge clk);
      chk("stall_ready_low", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      en        = 1'b1;
      cmd_valid = 1'b0;
      finish_cmd("shl4_stall", 5);

      issue(OP_LOAD, 4'd0, 8'hFF, 1'b0, 1'b1, "load_ff", 8'hFF);
      finish_cmd("load_ff", 0);
      issue(OP_SHL, 4'd5, 8'h00, 1'b0, 1'b0, "shl5_abort", 8'h00);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_dout", {24'd0, D_out}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
      repeat (6) @(negedge clk);
      chk("abort_no_done", done_cnt, 32'd0);

      issue(OP_SHL, 4'd15, 8'h00, 1'b1, 1'b1, "shl15_clamp", 8'hFF);
      finish_cmd("shl15_clamp", 7);
      issue(OP_SHR, 4'd15, 8'h00, 1'b0, 1'b1, "shr15_clamp", 8'h00);
      finish_cmd("shr15_clamp", 7);

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
